banked_fault_mem: RTL

- Parametrised behavioural memory model for the MBIST environment. Successor of the fixed two-bank, 8-bit word memory.
- Provides N banks of bit-addressed rows, each row read and written as WORD_W-bit words at an arbitrary column offset.
- Adds a runtime-programmable stuck-at fault table, so faults are injected by the testbench/BIST top without editing RTL.
- Adds a configurable read latency with a read-valid strobe and a per-read fault-hit flag.

---
 rtl/banked_fault_mem.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/banked_fault_mem.sv
// banked_fault_mem: banked, bit-addressed memory model with a runtime
// stuck-at fault table and a fixed-latency pipelined read path.
module banked_fault_mem #(
   parameter  int NUM_BANKS  = 4,
   parameter  int ROW_W      = 10,
   parameter  int COL_W      = 10,
   parameter  int WORD_W     = 8,
   parameter  int RD_LAT     = 1,
   parameter  int NUM_FAULTS = 8,
   localparam int BANK_W     = $clog2(NUM_BANKS),
   localparam int FI_W       = $clog2(NUM_FAULTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              we,
   input  logic [BANK_W-1:0] bank_addr,
   input  logic [ROW_W-1:0]  row_addr,
   input  logic [COL_W-1:0]  col_addr,
   input  logic [WORD_W-1:0] data_i,
   output logic [WORD_W-1:0] data_o,
   output logic              rd_valid_o,
   output logic              fault_hit_o,
   input  logic              flt_we,
   input  logic [FI_W-1:0]   flt_idx,
   input  logic              flt_en,
   input  logic              flt_val,
   input  logic [BANK_W-1:0] flt_bank,
   input  logic [ROW_W-1:0]  flt_row,
   input  logic [COL_W-1:0]  flt_col,
   output logic              addr_err_o
);

   localparam logic [BANK_W:0] NB = (BANK_W+1)'(NUM_BANKS);
   localparam int LAST = RD_LAT - 1;

   logic bank_ok;
   logic rd_issue;
   logic wr_issue;

   assign bank_ok  = {1'b0, bank_addr} < NB;
   assign rd_issue = ce && !we && bank_ok;
   assign wr_issue = ce && we && bank_ok;

   // Column c of a row lives in bit c of the packed row vector.
   logic [2**COL_W-1:0] mem_q [NUM_BANKS][2**ROW_W];

   logic              f_en_q   [NUM_FAULTS];
   logic              f_val_q  [NUM_FAULTS];
   logic [BANK_W-1:0] f_bank_q [NUM_FAULTS];
   logic [ROW_W-1:0]  f_row_q  [NUM_FAULTS];
   logic [COL_W-1:0]  f_col_q  [NUM_FAULTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NUM_FAULTS; j++) begin
            f_en_q[j]   <= 1'b0;
            f_val_q[j]  <= 1'b0;
            f_bank_q[j] <= '0;
            f_row_q[j]  <= '0;
            f_col_q[j]  <= '0;
         end
      end else if (flt_we) begin
         f_en_q[flt_idx]   <= flt_en;
         f_val_q[flt_idx]  <= flt_val;
         f_bank_q[flt_idx] <= flt_bank;
         f_row_q[flt_idx]  <= flt_row;
         f_col_q[flt_idx]  <= flt_col;
      end
   end

   // Faults mask reads only; the array always takes the write.
   always_ff @(posedge clk) begin
      if (wr_issue) begin
         for (int k = 0; k < WORD_W; k++) begin
            mem_q[bank_addr][row_addr][COL_W'(col_addr + COL_W'(k))]
               <= data_i[WORD_W-1-k];
         end
      end
   end

   logic [WORD_W-1:0] rd_word;
   logic              rd_hit;

   always_comb begin
      logic [COL_W-1:0] c;
      logic             b;
      logic             m;
      c       = '0;
      b       = 1'b0;
      m       = 1'b0;
      rd_word = '0;
      rd_hit  = 1'b0;
      for (int k = 0; k < WORD_W; k++) begin
         c = COL_W'(col_addr + COL_W'(k));
         b = mem_q[bank_addr][row_addr][c];
         m = 1'b0;
         for (int j = 0; j < NUM_FAULTS; j++) begin
            if (!m && f_en_q[j] && f_bank_q[j] == bank_addr &&
                f_row_q[j] == row_addr && f_col_q[j] == c) begin
               m = 1'b1;
               b = f_val_q[j];
            end
         end
         rd_word[WORD_W-1-k] = b;
         rd_hit = rd_hit | m;
      end
   end

   logic              v_q [RD_LAT];
   logic              h_q [RD_LAT];
   logic [WORD_W-1:0] d_q [RD_LAT];
   logic              v_s [RD_LAT];
   logic              h_s [RD_LAT];
   logic [WORD_W-1:0] d_s [RD_LAT];
   logic              addr_err_q;

   assign v_s[0] = rd_issue;
   assign h_s[0] = rd_issue && rd_hit;
   assign d_s[0] = rd_word;

   for (genvar i = 1; i < RD_LAT; i++) begin : g_stage
      assign v_s[i] = v_q[i-1];
      assign h_s[i] = h_q[i-1];
      assign d_s[i] = d_q[i-1];
   end

   // The output stage holds between reads, but clears after ce = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            v_q[i] <= 1'b0;
            h_q[i] <= 1'b0;
            d_q[i] <= '0;
         end
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= ce && !bank_ok;
         for (int i = 0; i < RD_LAT; i++) begin
            v_q[i] <= v_s[i];
            h_q[i] <= h_s[i];
            if (i != LAST)  d_q[i] <= d_s[i];
            else if (v_s[i]) d_q[i] <= d_s[i];
            else if (!ce)    d_q[i] <= '0;
         end
      end
   end

   assign data_o      = d_q[LAST];
   assign rd_valid_o  = v_q[LAST];
   assign fault_hit_o = h_q[LAST];
   assign addr_err_o  = addr_err_q;

endmodule
